// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared fetch-control definitions: reset vector, FSM state encoding and the
// BTB slot index that marks a branch in the last word of a fetch group.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hbfc00000;
  localparam logic [1:0]  SLOT_LAST        = 2'd3;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DSLOT  = 1'b1
  } fetch_state_t;

  // Start of the next 16-byte fetch group; wraps at the top of the address space.
  function automatic logic [31:0] next_group(input logic [31:0] pc);
    return {pc[31:4] + 28'd1, 4'b0000};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch-group PC register with exception/branch/BTB redirect and delay-slot sequencing.
// One-cycle update latency; when IF_allowin_i is low, all state holds unless a flush arrives.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_allowin_i,
  input  logic        BTB_predTake_i,
  input  logic [1:0]  BTB_predSlot_i,
  input  logic [31:0] BTB_predTarget_i,
  input  logic        BR_flush_i,
  input  logic [31:0] BR_target_i,
  input  logic        BR_needDelaySlot_i,
  input  logic [31:0] BR_dsVAddr_i,
  input  logic        EXC_flush_i,
  input  logic [31:0] EXC_target_i,
  output logic [31:0] PCR_VAddr_o,
  output logic [31:0] PCR_lastVAddr_o,
  output logic        PCR_needDelaySlot_o,
  output logic        PCR_valid_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  vaddr_q, vaddr_d;
  logic [31:0]  last_q, last_d;
  logic         valid_q;

  always_comb begin
    state_d = state_q;
    vaddr_d = vaddr_q;
    last_d  = last_q;
    if (EXC_flush_i) begin
      vaddr_d = EXC_target_i;
      last_d  = 32'h0;
      state_d = ST_NORMAL;
    end else if (BR_flush_i) begin
      vaddr_d = BR_target_i;
      if (BR_needDelaySlot_i) begin
        last_d  = BR_dsVAddr_i;
        state_d = ST_DSLOT;
      end else begin
        state_d = ST_NORMAL;
      end
    end else if (IF_allowin_i) begin
      if (state_q == ST_DSLOT) begin
        // The delay-slot group is issued from lastVAddr; the target waits in vaddr.
        state_d = ST_NORMAL;
      end else if (BTB_predTake_i && (BTB_predSlot_i == SLOT_LAST)) begin
        last_d  = next_group(vaddr_q);
        vaddr_d = BTB_predTarget_i;
        state_d = ST_DSLOT;
      end else if (BTB_predTake_i) begin
        vaddr_d = BTB_predTarget_i;
      end else begin
        vaddr_d = next_group(vaddr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_NORMAL;
      vaddr_q <= RESET_PC;
      last_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vaddr_q <= vaddr_d;
      last_q  <= last_d;
      valid_q <= 1'b1;
    end
  end

  assign PCR_VAddr_o         = vaddr_q;
  assign PCR_lastVAddr_o     = last_q;
  assign PCR_needDelaySlot_o = (state_q == ST_DSLOT);
  assign PCR_valid_o         = valid_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios plus random redirect traffic.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        allowin = 1'b0, take = 1'b0, br = 1'b0, brds = 1'b0, exc = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] tgt = '0, brt = '0, dsv = '0, exct = '0;
  logic [31:0] vaddr, lastv;
  logic        nds, valid;

  typedef struct {
    logic [31:0] v;
    logic [31:0] l;
    logic        ds;
    logic        val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state, tracked as plain address values plus a "delay slot pending" flag.
  logic [31:0] m_v = RPC, m_l = 32'h0;
  logic        m_ds = 1'b0;

  pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .IF_allowin_i(allowin),
    .BTB_predTake_i(take), .BTB_predSlot_i(slot), .BTB_predTarget_i(tgt),
    .BR_flush_i(br), .BR_target_i(brt), .BR_needDelaySlot_i(brds), .BR_dsVAddr_i(dsv),
    .EXC_flush_i(exc), .EXC_target_i(exct),
    .PCR_VAddr_o(vaddr), .PCR_lastVAddr_o(lastv),
    .PCR_needDelaySlot_o(nds), .PCR_valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("sb_vaddr", vaddr, e.v);
      chk("sb_last", lastv, e.l);
      chk("sb_ds", {31'b0, nds}, {31'b0, e.ds});
      chk("sb_valid", {31'b0, valid}, {31'b0, e.val});
    end
  end

  task automatic model_update();
    logic [31:0] seq;
    seq = (m_v & 32'hFFFF_FFF0) + 32'h10;
    if (exc) begin
      m_v = exct; m_l = 32'h0; m_ds = 1'b0;
    end else if (br) begin
      m_v = brt;
      if (brds) begin m_l = dsv; m_ds = 1'b1; end
      else m_ds = 1'b0;
    end else if (allowin) begin
      if (m_ds) m_ds = 1'b0;
      else if (take && slot == 2'd3) begin m_l = seq; m_v = tgt; m_ds = 1'b1; end
      else if (take) m_v = tgt;
      else m_v = seq;
    end
  endtask

  // Apply one cycle of inputs, then post the expected post-edge outputs.
  task automatic step(input logic a, input logic t, input logic [1:0] s, input logic [31:0] tg,
                      input logic b, input logic [31:0] bt, input logic bd, input logic [31:0] dv,
                      input logic x, input logic [31:0] xt);
    exp_t e;
    allowin = a; take = t; slot = s; tgt = tg;
    br = b; brt = bt; brds = bd; dsv = dv; exc = x; exct = xt;
    model_update();
    @(posedge clk);
    #1;
    e.v = m_v; e.l = m_l; e.ds = m_ds; e.val = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic seq_step(input logic a);
    step(a, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic br_step(input logic [31:0] bt, input logic bd, input logic [31:0] dv);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, bt, bd, dv, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    m_v = RPC; m_l = 32'h0; m_ds = 1'b0;
    #1;
    chk("rst_vaddr", vaddr, RPC);
    chk("rst_last", lastv, 32'h0);
    chk("rst_ds", {31'b0, nds}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();

    // Sequential fetch out of reset.
    seq_step(1'b1);
    chk("seq1", vaddr, 32'hbfc00010);
    chk("seq1_valid", {31'b0, valid}, 32'h1);
    seq_step(1'b1);
    chk("seq2", vaddr, 32'hbfc00020);

    // Taken prediction in slot 1.
    br_step(32'h80000010, 1'b0, 32'h0);
    step(1'b1, 1'b1, 2'd1, 32'h80001000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("slot1_vaddr", vaddr, 32'h80001000);
    chk("slot1_ds", {31'b0, nds}, 32'h0);

    // Taken prediction in the last slot, stall, then drain the delay slot.
    br_step(32'h80000010, 1'b0, 32'h0);
    step(1'b1, 1'b1, 2'd3, 32'h80002000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("slot3_last", lastv, 32'h80000020);
    chk("slot3_vaddr", vaddr, 32'h80002000);
    chk("slot3_ds", {31'b0, nds}, 32'h1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 2'd1, 32'h12345670, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_vaddr", vaddr, 32'h80002000);
    chk("hold_ds", {31'b0, nds}, 32'h1);
    step(1'b1, 1'b1, 2'd2, 32'h9999_0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("ds_done_ds", {31'b0, nds}, 32'h0);
    chk("ds_done_vaddr", vaddr, 32'h80002000);

    // Branch redirect with delay slot, then exception overriding a branch while stalled.
    br_step(32'h80003000, 1'b1, 32'h80000040);
    chk("br_last", lastv, 32'h80000040);
    chk("br_vaddr", vaddr, 32'h80003000);
    chk("br_ds", {31'b0, nds}, 32'h1);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h80004000, 1'b1, 32'h80000050, 1'b1, 32'hbfc00380);
    chk("exc_vaddr", vaddr, 32'hbfc00380);
    chk("exc_ds", {31'b0, nds}, 32'h0);
    chk("exc_last", lastv, 32'h0);

    // Address-space wrap.
    br_step(32'hFFFFFFF0, 1'b0, 32'h0);
    seq_step(1'b1);
    chk("wrap", vaddr, 32'h00000000);

    // Randomised redirect traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(2) == 0), 2'($urandom_range(3)),
           {$urandom, 2'b00} & 32'hFFFF_FFFC,
           ($urandom_range(7) == 0), $urandom & 32'hFFFF_FFF0, $urandom_range(1) == 1,
           $urandom & 32'hFFFF_FFF0,
           ($urandom_range(15) == 0), $urandom & 32'hFFFF_FFF0);
    end

    // Reset arriving mid delay-slot sequence.
    br_step(32'h80005000, 1'b1, 32'h80000060);
    @(negedge clk);
    #1;
    chk("pre_rst_ds", {31'b0, nds}, 32'h1);
    do_reset();
    seq_step(1'b1);
    chk("post_rst", vaddr, 32'hbfc00010);

    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(3) != 0), ($urandom_range(1) == 0), 2'($urandom_range(3)),
           $urandom, ($urandom_range(5) == 0), $urandom, $urandom_range(1) == 1, $urandom,
           ($urandom_range(11) == 0), $urandom);
    end
    seq_step(1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
